// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage: PC register, redirect, stall and IF/ID register
// The only control state is ValidD; priority at each edge is reset, redirect, stall, normal.
module fetch_stage #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic [31:0]           fetch_count
);

    logic [DATA_WIDTH-1:0] pcf;
    logic [DATA_WIDTH-1:0] pc_plus4_f;

    assign pc_plus4_f = pcf + DATA_WIDTH'(4);
    assign imem_addr  = pcf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcf         <= RESET_PC;
            InstrD      <= NOP_INSTR;
            PCD         <= '0;
            PCPlus4D    <= '0;
            ValidD      <= 1'b0;
            fetch_count <= '0;
        end else if (PCSrc) begin
            // Flush drops the wrong-path fetch; PCD/PCPlus4D keep their last values.
            pcf    <= {PCTarget[DATA_WIDTH-1:2], 2'b00};
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!stall) begin
            pcf         <= pc_plus4_f;
            InstrD      <= instr_rdata;
            PCD         <= pcf;
            PCPlus4D    <= pc_plus4_f;
            ValidD      <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, pcsrc;
    logic [31:0] target, rdata, addr, instr_d, pcd, pcp4d, cnt;
    logic        valid_d;

    logic        rst_w;
    logic [31:0] rdata_w, addr_w, instr_w, pcd_w, pcp4_w, cnt_w;
    logic        valid_w;

    // Memory image: word at byte address a is 0x13 + (a/4 << 7).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 2;
        return 32'h13 + (idx << 7);
    endfunction

    assign rdata   = mem_word(addr);
    assign rdata_w = mem_word(addr_w);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .PCSrc(pcsrc), .PCTarget(target),
        .instr_rdata(rdata), .imem_addr(addr), .InstrD(instr_d), .PCD(pcd),
        .PCPlus4D(pcp4d), .ValidD(valid_d), .fetch_count(cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_w), .stall(1'b0), .PCSrc(1'b0), .PCTarget(32'h0),
        .instr_rdata(rdata_w), .imem_addr(addr_w), .InstrD(instr_w), .PCD(pcd_w),
        .PCPlus4D(pcp4_w), .ValidD(valid_w), .fetch_count(cnt_w)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[15];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic [31:0] t,
                                input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] d,
                                input logic [31:0] d4, input logic v, input logic [31:0] c);
        vec_t x;
        x.rst_n = r; x.stall = s; x.pcsrc = p; x.target = t;
        x.pcf = pc; x.instr = ins; x.pcd = d; x.p4 = d4; x.valid = v; x.cnt = c;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = '0; rst_w = 1'b0;

        //            rst stl src target        pcf           instr         pcd           pcplus4d      v cnt
        vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h13,   32'h0,   32'h0,   0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h13,   32'h0,   32'h0,   0, 0);
        vecs[2]  = mk(1, 0, 0, 32'h0,   32'h4,   32'h13,   32'h0,   32'h4,   1, 1);
        vecs[3]  = mk(1, 0, 0, 32'h0,   32'h8,   32'h93,   32'h4,   32'h8,   1, 2);
        vecs[4]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h93,   32'h4,   32'h8,   1, 2);
        vecs[5]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h93,   32'h4,   32'h8,   1, 2);
        vecs[6]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h93,   32'h4,   32'h8,   1, 2);
        vecs[7]  = mk(1, 0, 0, 32'h0,   32'hC,   32'h113,  32'h8,   32'hC,   1, 3);
        vecs[8]  = mk(1, 0, 0, 32'h0,   32'h10,  32'h193,  32'hC,   32'h10,  1, 4);
        vecs[9]  = mk(1, 0, 1, 32'h40,  32'h40,  32'h13,   32'hC,   32'h10,  0, 4);
        vecs[10] = mk(1, 0, 0, 32'h0,   32'h44,  32'h813,  32'h40,  32'h44,  1, 5);
        vecs[11] = mk(1, 1, 1, 32'h103, 32'h100, 32'h13,   32'h40,  32'h44,  0, 5);
        vecs[12] = mk(1, 0, 0, 32'h0,   32'h104, 32'h2013, 32'h100, 32'h104, 1, 6);
        vecs[13] = mk(0, 0, 1, 32'h40,  32'h0,   32'h13,   32'h0,   32'h0,   0, 0);
        vecs[14] = mk(1, 0, 0, 32'h0,   32'h4,   32'h13,   32'h0,   32'h4,   1, 1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; stall = vecs[i].stall;
            pcsrc = vecs[i].pcsrc; target = vecs[i].target;
            @(posedge clk);
            #1;
            check($sformatf("v%0d imem_addr", i), addr, vecs[i].pcf);
            check($sformatf("v%0d InstrD", i), instr_d, vecs[i].instr);
            check($sformatf("v%0d PCD", i), pcd, vecs[i].pcd);
            check($sformatf("v%0d PCPlus4D", i), pcp4d, vecs[i].p4);
            check($sformatf("v%0d ValidD", i), {31'b0, valid_d}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d fetch_count", i), cnt, vecs[i].cnt);
        end

        // Stall must not reach imem_addr combinationally.
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("stall_comb imem_addr", addr, 32'h4);
        stall = 1'b0;

        // PC wrap from the top of the address space.
        check("wrap reset PCF", addr_w, 32'hFFFF_FFF8);
        check("wrap reset ValidD", {31'b0, valid_w}, 32'h0);
        @(negedge clk);
        rst_w = 1'b1;
        @(posedge clk); #1;
        check("wrap1 PCD", pcd_w, 32'hFFFF_FFF8);
        check("wrap1 PCPlus4D", pcp4_w, 32'hFFFF_FFFC);
        check("wrap1 InstrD", instr_w, 32'hFFFF_FF13);
        @(posedge clk); #1;
        check("wrap2 PCD", pcd_w, 32'hFFFF_FFFC);
        check("wrap2 PCPlus4D", pcp4_w, 32'h0);
        check("wrap2 InstrD", instr_w, 32'hFFFF_FF93);
        check("wrap2 PCF", addr_w, 32'h0);
        @(posedge clk); #1;
        check("wrap3 PCD", pcd_w, 32'h0);
        check("wrap3 InstrD", instr_w, 32'h13);
        check("wrap3 fetch_count", cnt_w, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
